// File: rtl/spatz_boot_sequencer.sv
// Boot sequencer: waits a settle time, writes the latched entry point to the boot-control
// register over reqrsp, then pulses debug_req_o. Define SPATZ_BOOT_TIMEOUT_EN for a response timeout.
module spatz_boot_sequencer #(
  parameter int unsigned              AddrWidth     = 48,
  parameter int unsigned              DataWidth     = 64,
  parameter int unsigned              NumCores      = 1,
  parameter logic [AddrWidth-1:0]     BootCtrlAddr  = '0,
  parameter int unsigned              SettleCycles  = 1000,
  parameter int unsigned              WakeCycles    = 1,
  parameter int unsigned              TimeoutCycles = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            entry_point_i,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic                   p_valid_i,
  input  logic                   p_error_i,
  output logic                   p_ready_o,
  output logic [NumCores-1:0]    debug_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  // One counter serves settle, wake and timeout phases, so it is sized for the largest.
  localparam int unsigned SettleWake = (SettleCycles > WakeCycles) ? SettleCycles : WakeCycles;
  localparam int unsigned CntMax     = (TimeoutCycles > SettleWake) ? TimeoutCycles : SettleWake;
  localparam int unsigned CntWidth   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    REQ    = 3'd2,
    RESP   = 3'd3,
    WAKE   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [31:0]         entry_q;

  // NOTE: every output is a register updated on the transition into the state that
  // asserts it, so no input ever reaches an output combinationally. All state uses <=
  // so every branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      entry_q     <= '0;
      q_addr_o    <= '0;
      q_data_o    <= '0;
      q_write_o   <= 1'b0;
      q_strb_o    <= '0;
      q_valid_o   <= 1'b0;
      p_ready_o   <= 1'b0;
      debug_req_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            entry_q <= entry_point_i;
            cnt_q   <= CntWidth'(SettleCycles - 1);
            busy_o  <= 1'b1;
            state_q <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            q_valid_o <= 1'b1;
            q_addr_o  <= BootCtrlAddr;
            q_data_o  <= DataWidth'(entry_q);
            q_write_o <= 1'b1;
            q_strb_o  <= '1;
            state_q   <= REQ;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // q_valid_o is high throughout REQ, so q_ready_i alone completes the handshake.
        REQ: begin
          if (q_ready_i) begin
            q_valid_o <= 1'b0;
            q_addr_o  <= '0;
            q_data_o  <= '0;
            q_write_o <= 1'b0;
            q_strb_o  <= '0;
            p_ready_o <= 1'b1;
`ifdef SPATZ_BOOT_TIMEOUT_EN
            cnt_q     <= CntWidth'(TimeoutCycles - 1);
`endif
            state_q   <= RESP;
          end
        end

        RESP: begin
          if (p_valid_i) begin
            p_ready_o <= 1'b0;
            if (p_error_i) begin
              busy_o  <= 1'b0;
              error_o <= 1'b1;
              state_q <= ERROR;
            end else begin
              debug_req_o <= '1;
              cnt_q       <= CntWidth'(WakeCycles - 1);
              state_q     <= WAKE;
            end
`ifdef SPATZ_BOOT_TIMEOUT_EN
          end else if (cnt_q == '0) begin
            p_ready_o <= 1'b0;
            busy_o    <= 1'b0;
            error_o   <= 1'b1;
            state_q   <= ERROR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`else
          end
`endif
        end

        WAKE: begin
          if (cnt_q == '0) begin
            debug_req_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // Terminal states hold until start_i drops, so a held start never re-boots.
        DONE, ERROR: begin
          if (!start_i) begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spatz_boot_sequencer.sv
// Directed bench for spatz_boot_sequencer with SettleCycles=4, WakeCycles=1, TimeoutCycles=8.
module tb_spatz_boot_sequencer;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned NC = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   entry_point_i = '0;
  logic [AW-1:0] q_addr_o;
  logic [DW-1:0] q_data_o;
  logic          q_write_o;
  logic [DW/8-1:0] q_strb_o;
  logic          q_valid_o;
  logic          q_ready_i = 1'b0;
  logic          p_valid_i = 1'b0;
  logic          p_error_i = 1'b0;
  logic          p_ready_o;
  logic [NC-1:0] debug_req_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  int n_checks = 0;
  int n_fails  = 0;
  int n_hs     = 0;
  logic dbg_seen = 1'b0;

  spatz_boot_sequencer #(
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .NumCores      (NC),
    .BootCtrlAddr  (48'h0000_0200_0040),
    .SettleCycles  (4),
    .WakeCycles    (1),
    .TimeoutCycles (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .entry_point_i (entry_point_i),
    .q_addr_o      (q_addr_o),
    .q_data_o      (q_data_o),
    .q_write_o     (q_write_o),
    .q_strb_o      (q_strb_o),
    .q_valid_o     (q_valid_o),
    .q_ready_i     (q_ready_i),
    .p_valid_i     (p_valid_i),
    .p_error_i     (p_error_i),
    .p_ready_o     (p_ready_o),
    .debug_req_o   (debug_req_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (q_valid_o && q_ready_i) n_hs++;
    if (debug_req_o != '0) dbg_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " q_valid"}, 64'(q_valid_o), 64'd0);
    check({tag, " q_addr"},  64'(q_addr_o),  64'd0);
    check({tag, " q_data"},  q_data_o,       64'd0);
    check({tag, " q_strb"},  64'(q_strb_o),  64'd0);
    check({tag, " q_write"}, 64'(q_write_o), 64'd0);
    check({tag, " p_ready"}, 64'(p_ready_o), 64'd0);
    check({tag, " debug"},   64'(debug_req_o), 64'd0);
  endtask

  task automatic check_req(input string tag, input logic [63:0] data);
    check({tag, " q_valid"}, 64'(q_valid_o), 64'd1);
    check({tag, " q_addr"},  64'(q_addr_o),  64'h0000_0200_0040);
    check({tag, " q_data"},  q_data_o,       data);
    check({tag, " q_strb"},  64'(q_strb_o),  64'hFF);
    check({tag, " q_write"}, 64'(q_write_o), 64'd1);
    check({tag, " p_ready"}, 64'(p_ready_o), 64'd0);
  endtask

  initial begin
    int hs_ref;
    int lat;

    // Reset state
    #12;
    check_idle_outputs("reset");
    check("reset busy",  64'(busy_o),  64'd0);
    check("reset done",  64'(done_o),  64'd0);
    check("reset error", 64'(error_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Nominal: ready and response held high from the start
    q_ready_i = 1'b1;
    p_valid_i = 1'b1;
    start_i = 1'b1;
    entry_point_i = 32'h8000_0000;
    tick();                                   // edge 0: accept
    entry_point_i = 32'hDEAD_BEEF;            // must be ignored after latching
    check("nom busy", 64'(busy_o), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      check("nom settle valid", 64'(q_valid_o), 64'd0);
      tick();
    end
    check("nom settle valid c3", 64'(q_valid_o), 64'd0);
    tick();                                   // edge 4: REQ
    check_req("nom req", 64'h0000_0000_8000_0000);
    tick();                                   // edge 5: RESP
    check("nom resp p_ready", 64'(p_ready_o), 64'd1);
    check("nom resp q_valid", 64'(q_valid_o), 64'd0);
    check("nom resp debug",   64'(debug_req_o), 64'd0);
    tick();                                   // edge 6: WAKE
    check("nom wake debug",   64'(debug_req_o), 64'd3);
    check("nom wake p_ready", 64'(p_ready_o), 64'd0);
    tick();                                   // edge 7: DONE
    check("nom done",       64'(done_o), 64'd1);
    check("nom done debug", 64'(debug_req_o), 64'd0);
    check("nom done busy",  64'(busy_o), 64'd0);
    check("nom handshakes", 64'(n_hs), 64'd1);

    // Held start through DONE must not trigger a second request
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hold q_valid", 64'(q_valid_o), 64'd0);
      check("hold done",    64'(done_o), 64'd1);
    end
    check("hold handshakes", 64'(n_hs), 64'd1);
    start_i = 1'b0;
    tick();
    check("drop done", 64'(done_o), 64'd0);
    check("drop busy", 64'(busy_o), 64'd0);

    // Restart with entry 0x1234 plus request/response backpressure
    q_ready_i = 1'b0;
    p_valid_i = 1'b0;
    start_i = 1'b1;
    entry_point_i = 32'h0000_1234;
    hs_ref = n_hs;
    dbg_seen = 1'b0;
    repeat (5) tick();                        // edges 0..4
    check_req("bp req", 64'h0000_0000_0000_1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_req("bp stall", 64'h0000_0000_0000_1234);
    end
    q_ready_i = 1'b1;
    tick();
    q_ready_i = 1'b0;
    check("bp resp q_valid", 64'(q_valid_o), 64'd0);
    check("bp resp p_ready", 64'(p_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp wait debug",   64'(debug_req_o), 64'd0);
      check("bp wait p_ready", 64'(p_ready_o), 64'd1);
    end
    check("bp no early wake", 64'(dbg_seen), 64'd0);
    p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    check("bp wake debug", 64'(debug_req_o), 64'd3);
    tick();
    check("bp done", 64'(done_o), 64'd1);
    check("bp single handshake", 64'(n_hs), 64'(hs_ref + 1));
    start_i = 1'b0;
    tick();

    // Error response
    dbg_seen = 1'b0;
    q_ready_i = 1'b1;
    start_i = 1'b1;
    entry_point_i = 32'h0000_5678;
    repeat (6) tick();                        // accept, settle, REQ, RESP
    check("err resp p_ready", 64'(p_ready_o), 64'd1);
    p_valid_i = 1'b1;
    p_error_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    p_error_i = 1'b0;
    check("err error", 64'(error_o), 64'd1);
    check("err done",  64'(done_o),  64'd0);
    check("err busy",  64'(busy_o),  64'd0);
    tick();
    check("err hold",     64'(error_o), 64'd1);
    check("err no wake",  64'(dbg_seen), 64'd0);
    start_i = 1'b0;
    tick();
    check("err cleared", 64'(error_o), 64'd0);

    // Reset while the request is pending
    q_ready_i = 1'b0;
    start_i = 1'b1;
    entry_point_i = 32'h0000_0ABC;
    repeat (5) tick();
    check("rst pre q_valid", 64'(q_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("rst abort");
    check("rst abort busy", 64'(busy_o), 64'd0);
    #1;
    rst_ni = 1'b1;
    q_ready_i = 1'b1;
    tick();                                   // fresh accept
    lat = 0;
    while (!q_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("rst resettle latency", 64'(lat), 64'd4);
    tick();
    p_valid_i = 1'b1;
    repeat (2) tick();
    p_valid_i = 1'b0;
    check("rst rerun done", 64'(done_o), 64'd1);
    start_i = 1'b0;
    tick();

`ifdef SPATZ_BOOT_TIMEOUT_EN
    // Timeout with no response: ERROR 8 cycles after entering RESP
    start_i = 1'b1;
    q_ready_i = 1'b1;
    repeat (6) tick();                        // now in RESP
    q_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to waiting", 64'(error_o), 64'd0);
    end
    tick();
    check("to error", 64'(error_o), 64'd1);
    start_i = 1'b0;
    tick();

    // Response in the final counting cycle wins over timeout
    start_i = 1'b1;
    q_ready_i = 1'b1;
    repeat (6) tick();
    q_ready_i = 1'b0;
    repeat (7) tick();
    p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    check("to late resp wake",  64'(debug_req_o), 64'd3);
    check("to late resp error", 64'(error_o), 64'd0);
    start_i = 1'b0;
    repeat (2) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
